// File: rtl/datamemory_dump.sv
// Read-side dump engine for the data memory: walks cells 0..CELDAS-1 and streams
// each word to the UART transmitter as two bytes, high byte first.
module datamemory_dump #(
  parameter int unsigned NBITS_O = 11,
  parameter int unsigned NBITS_D = 16,
  parameter int unsigned NBITS_B = 8,
  parameter int unsigned CELDAS  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_Rd,
  output logic               o_Wr,
  output logic [NBITS_O-1:0] o_Addr,
  input  logic [NBITS_D-1:0] i_MemData,
  output logic [NBITS_B-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StSend = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [NBITS_O-1:0] LastAddr = NBITS_O'(CELDAS - 1);

  logic [2:0]         state_q, state_d;
  logic [NBITS_O-1:0] addr_q, addr_d;
  logic               rd_q, rd_d;
  logic [NBITS_B-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  // Only the low byte needs keeping; the high byte is sent straight from i_MemData.
  logic [NBITS_B-1:0] word_lo_q, word_lo_d;
  logic               sel_lo_q, sel_lo_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_d       = 1'b0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    word_lo_d  = word_lo_q;
    sel_lo_d   = sel_lo_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StReq;
          addr_d  = '0;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StReq: begin
        word_lo_d  = i_MemData[NBITS_B-1:0];
        sel_lo_d   = 1'b0;
        tx_data_d  = i_MemData[NBITS_D-1 -: NBITS_B];
        tx_start_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        state_d = StWait;
      end
      StWait: begin
        if (i_tx_done) begin
          if (!sel_lo_q) begin
            sel_lo_d   = 1'b1;
            tx_data_d  = word_lo_q;
            tx_start_d = 1'b1;
            state_d    = StSend;
          end else if (addr_q != LastAddr) begin
            addr_d  = addr_q + NBITS_O'(1);
            rd_d    = 1'b1;
            state_d = StReq;
          end else begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        addr_d  = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      word_lo_q  <= '0;
      sel_lo_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      word_lo_q  <= word_lo_d;
      sel_lo_q   <= sel_lo_d;
    end
  end

  assign o_Rd       = rd_q;
  assign o_Wr       = 1'b0;
  assign o_Addr     = addr_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule
